// File: rtl/horizontal_line_plotter.sv
// Rasterizes a filled horizontal bar, one pixel per accepted cycle, row-major.
// Owns its start/busy/done handshake and stalls on downstream ready.
module horizontal_line_plotter #(
  parameter int COORD_W  = 5,
  parameter int COLOUR_W = 3
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic                start,
  input  logic [COORD_W-1:0]  x,
  input  logic [COORD_W-1:0]  y,
  input  logic [COORD_W-1:0]  length,
  input  logic [1:0]          thickness,
  input  logic [COLOUR_W-1:0] colour,
  input  logic                ready,
  output logic [COORD_W-1:0]  xOut,
  output logic [COORD_W-1:0]  yOut,
  output logic [COLOUR_W-1:0] colourOut,
  output logic                plot,
  output logic                busy,
  output logic                done
);

  typedef enum logic [1:0] {IDLE, DRAW, FIN} state_t;

  state_t              state, state_nxt;
  logic [COORD_W-1:0]  x_l, y_l, len_l;
  logic [1:0]          thk_l;
  logic [COLOUR_W-1:0] col_l;
  logic [COORD_W-1:0]  xcnt;
  logic [1:0]          ycnt;
  logic                accept, last_x, last_y;

  // Board coordinates wrap modulo 2**COORD_W; no clamping.
  function automatic logic [COORD_W-1:0] coord_add(input logic [COORD_W-1:0] a,
                                                   input logic [COORD_W-1:0] b);
    logic [COORD_W:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[COORD_W-1:0];
  endfunction

  assign accept = (state == DRAW) && ready;
  assign last_x = (xcnt == len_l);
  assign last_y = (ycnt == thk_l);

  always_ff @(posedge clk) begin
    if (!resetn) state <= IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    plot      = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE: if (start) state_nxt = DRAW;
      DRAW: begin
        plot = 1'b1;
        busy = 1'b1;
        if (accept && last_x && last_y) state_nxt = FIN;
      end
      FIN: begin
        busy      = 1'b1;
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      x_l   <= '0;
      y_l   <= '0;
      len_l <= '0;
      thk_l <= '0;
      col_l <= '0;
      xcnt  <= '0;
      ycnt  <= '0;
    end else if (state == IDLE && start) begin
      x_l   <= x;
      y_l   <= y;
      len_l <= length;
      thk_l <= thickness;
      col_l <= colour;
      xcnt  <= '0;
      ycnt  <= '0;
    end else if (accept && !(last_x && last_y)) begin
      // End of a row restarts the column count and steps down one row.
      if (last_x) begin
        xcnt <= '0;
        ycnt <= ycnt + 2'd1;
      end else begin
        xcnt <= xcnt + 1'b1;
      end
    end
  end

  assign xOut      = coord_add(x_l, xcnt);
  assign yOut      = coord_add(y_l, {{(COORD_W-2){1'b0}}, ycnt});
  assign colourOut = col_l;

endmodule

// File: tb/tb_horizontal_line_plotter.sv
// Scoreboard bench for horizontal_line_plotter: directed bars queue expected
// pixels/done; a negedge monitor pops and compares whatever the DUT presents.
module tb_horizontal_line_plotter;

  logic       clk = 1'b0;
  logic       resetn, start, ready;
  logic [4:0] x, y, length;
  logic [1:0] thickness;
  logic [2:0] colour;
  logic [4:0] xOut, yOut;
  logic [2:0] colourOut;
  logic       plot, busy, done;

  typedef struct {
    bit         is_done;
    logic [4:0] px;
    logic [4:0] py;
    logic [2:0] pc;
  } exp_t;

  exp_t sb[$];
  int   vectors = 0;
  int   miscompares = 0;
  bit   prev_accept = 1'b0;

  horizontal_line_plotter #(.COORD_W(5), .COLOUR_W(3)) dut (
    .clk(clk), .resetn(resetn), .start(start), .x(x), .y(y), .length(length),
    .thickness(thickness), .colour(colour), .ready(ready), .xOut(xOut),
    .yOut(yOut), .colourOut(colourOut), .plot(plot), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  function automatic void check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endfunction

  // Monitor: every presented pixel, stall and done pulse is checked against the queue front.
  always @(negedge clk) begin
    exp_t e;
    if (plot === 1'b1 && done === 1'b1) check("done_with_plot", 1, 0);
    if (plot === 1'b1 && resetn === 1'b1) begin
      if (sb.size() == 0) check("unexpected_pixel", {xOut, yOut}, 0);
      else begin
        e = sb[0];
        check("pixel_kind", e.is_done, 0);
        check("pixel_xy", {xOut, yOut}, {e.px, e.py});
        check("pixel_colour", colourOut, e.pc);
        if (ready === 1'b1) void'(sb.pop_front());
      end
    end
    if (done === 1'b1) begin
      if (sb.size() == 0) check("unexpected_done", 1, 0);
      else begin
        e = sb.pop_front();
        check("done_kind", e.is_done, 1);
        check("done_after_last_accept", prev_accept, 1);
      end
    end
    prev_accept = (plot === 1'b1) && (ready === 1'b1) && (resetn === 1'b1);
  end

  task automatic push_bar(input logic [4:0] bx, input logic [4:0] by, input logic [4:0] bl,
                          input logic [1:0] bt, input logic [2:0] bc);
    exp_t e;
    logic [4:0] cx, cy;
    for (int r = 0; r <= int'(bt); r++) begin
      for (int c = 0; c <= int'(bl); c++) begin
        cx = bx + 5'(c);
        cy = by + 5'(r);
        e.is_done = 1'b0; e.px = cx; e.py = cy; e.pc = bc;
        sb.push_back(e);
      end
    end
    e.is_done = 1'b1; e.px = '0; e.py = '0; e.pc = '0;
    sb.push_back(e);
  endtask

  // Issues one bar; rpat gives ready for the first 8 DRAW cycles (bit 0 first).
  task automatic run_bar(input logic [4:0] bx, input logic [4:0] by, input logic [4:0] bl,
                         input logic [1:0] bt, input logic [2:0] bc, input logic [7:0] rpat,
                         input bit extra_start);
    push_bar(bx, by, bl, bt, bc);
    x = bx; y = by; length = bl; thickness = bt; colour = bc;
    start = 1'b1; ready = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    x = ~bx; y = ~by; length = ~bl; thickness = ~bt; colour = ~bc;
    for (int c = 0; c < 300 && sb.size() != 0; c++) begin
      ready = (c < 8) ? rpat[c] : 1'b1;
      if (extra_start && c == 1) begin
        start = 1'b1; x = 5'd0;
      end else start = 1'b0;
      @(posedge clk); #1;
    end
    start = 1'b0; ready = 1'b1;
    check("bar_drained", sb.size(), 0);
    sb.delete();
    check("busy_low_after_done", {busy, done, plot}, 3'b000);
  endtask

  initial begin
    resetn = 1'b0; start = 1'b0; ready = 1'b0;
    x = '0; y = '0; length = '0; thickness = '0; colour = '0;
    for (int i = 0; i < 7; i++) begin
      if (i == 2) resetn = 1'b1;
      @(posedge clk); #1;
      check("reset_idle_outputs", {xOut, yOut, colourOut, plot, busy, done}, 0);
    end

    run_bar(5'd3, 5'd4, 5'd2, 2'd0, 3'd5, 8'hFF, 1'b0);
    run_bar(5'd10, 5'd20, 5'd1, 2'd1, 3'd2, 8'hFF, 1'b1);
    run_bar(5'd7, 5'd9, 5'd2, 2'd0, 3'd6, 8'b1111_1001, 1'b0);
    run_bar(5'd30, 5'd31, 5'd3, 2'd1, 3'd7, 8'hFF, 1'b0);
    run_bar(5'd0, 5'd0, 5'd0, 2'd3, 3'd1, 8'b1111_0101, 1'b0);

    // Abort a 4-pixel bar with reset right after its 2nd pixel is accepted.
    push_bar(5'd12, 5'd6, 5'd3, 2'd0, 3'd4);
    x = 5'd12; y = 5'd6; length = 5'd3; thickness = 2'd0; colour = 3'd4;
    start = 1'b1; ready = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    resetn = 1'b0;
    @(posedge clk); #1;
    resetn = 1'b1;
    check("abort_outputs", {xOut, yOut, colourOut, plot, busy, done}, 0);
    check("abort_remaining", sb.size(), 3);
    sb.delete();
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check("abort_no_done", {plot, busy, done}, 3'b000);
    end
    run_bar(5'd12, 5'd6, 5'd3, 2'd0, 3'd4, 8'hFF, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/horizontal_line_plotter.md
# horizontal_line_plotter

Rasterizes a filled horizontal bar on the game-board pixel grid: a single start pulse latches origin, length, thickness and colour, and the block emits one pixel coordinate per accepted cycle with a plot strobe. It sits between the board-drawing control FSM and the VGA plot interface. It is the row-major counterpart of the column-drawing line generator. Unlike that generator, it owns its own start/busy/done handshake and respects a downstream ready.

## Interface
- COORD_W, 5, width of x, y, length and coordinate outputs
- COLOUR_W, 3, width of colour in/out
- clk  in  1  clock; all state changes on rising edge
- resetn  in  1  reset, synchronous, active-low
- start  in  1  request; sampled only in IDLE
- x  in  COORD_W  origin column (leftmost pixel)
- y  in  COORD_W  origin row (top pixel)
- length  in  COORD_W  columns minus one (0 → 1 column)
- thickness  in  2  rows minus one (0 → 1 row, 3 → 4 rows)
- colour  in  COLOUR_W  pixel colour
- ready  in  1  downstream accepts current pixel this cycle
- xOut  out  COORD_W  current pixel column
- yOut  out  COORD_W  current pixel row
- colourOut  out  COLOUR_W  latched colour
- plot  out  1  current pixel valid
- busy  out  1  high whenever state ≠ IDLE
- done  out  1  one-cycle completion pulse

## Operation
- States: IDLE, DRAW, DONE.
- IDLE:
  - plot=0, busy=0, done=0.
  - start=1 latches x, y, length, thickness, colour; clears xcnt and ycnt; next state DRAW.
- DRAW:
  - plot=1, busy=1.
  - xOut = x_l + xcnt; yOut = y_l + ycnt; colourOut = colour_l.
  - Pixel advances only on a cycle with ready=1. ready=0 holds xcnt, ycnt and all outputs unchanged.
  - On accept with xcnt ≠ length: xcnt+1.
  - On accept with xcnt == length and ycnt ≠ thickness: xcnt=0, ycnt+1.
  - On accept with xcnt == length and ycnt == thickness: next state DONE.
- DONE: done=1, busy=1, plot=0; next state IDLE unconditionally.
- Pixel order is row-major, left to right, top to bottom. Total pixels = (length+1)·(thickness+1), maximum 32·4 = 128.
- Arithmetic:
  - Coordinate sums are COORD_W-bit, truncated: they wrap modulo 32, with no clamping and no error.
  - xcnt is COORD_W bits; ycnt is 2 bits.
- start while busy=1 (DRAW or DONE) is ignored and not queued.
- Inputs x, y, length, thickness and colour are don't-care except on the start-accept cycle. Changing them mid-draw has no effect.
- Reset behaviour:
  - resetn=0 at any edge forces IDLE and clears xcnt, ycnt and all latched registers, including mid-draw.
  - No done pulse is produced for an aborted draw.
- All outputs are decoded from registers only; there is no combinational path from inputs to outputs.

## Timing
- Reset values: xOut=0, yOut=0, colourOut=0, plot=0, busy=0, done=0.
- start high at edge k (in IDLE) → plot=1 with the first pixel during cycle k+1.
- With ready tied high, N pixels occupy cycles k+1…k+N, done=1 in cycle k+N+1, and busy falls at k+N+2.
- Earliest next accepted start is at edge k+N+2, giving N+2 cycles per bar.
- Each ready=0 cycle in DRAW adds exactly one cycle of latency.
- ready is ignored outside DRAW.
- done is exactly one cycle wide and never coincides with plot.

## Test plan
- Reset/idle:
  - Stimulus: hold resetn=0 for 2 cycles, release, keep start=0 for 5 cycles.
  - Response: all outputs 0 throughout.
- Single row:
  - Stimulus: x=3, y=4, length=2, thickness=0, colour=5, ready=1, start pulse.
  - Response: plot high exactly 3 cycles with (3,4),(4,4),(5,4), colourOut=5; then done for 1 cycle; busy low the cycle after.
- Multi-row plus ignored start:
  - Stimulus: x=10, y=20, length=1, thickness=1.
  - Response: (10,20),(11,20),(10,21),(11,21).
  - Stimulus: a second start with x=0 asserted during DRAW.
  - Response: ignored; exactly 4 plot cycles and one done.
- Backpressure:
  - Stimulus: length=2, thickness=0, ready pattern 1,0,0,1,1.
  - Response: xOut sequence x,x+1,x+1,x+1,x+2; exactly 3 accepted pixels; done one cycle after the last accept.
- Wrap-around:
  - Stimulus: x=30, y=31, length=3, thickness=1.
  - Response: row 31 columns 30,31,0,1; then row 0 columns 30,31,0,1; done after 8 pixels.
- Reset mid-operation:
  - Stimulus: assert resetn=0 for one cycle after the 2nd pixel of a 4-pixel bar.
  - Response: next cycle plot=0, busy=0, outputs 0, no done pulse.
  - Stimulus: a fresh start afterwards.
  - Response: the full bar is drawn from its first pixel.
